// File: rtl/code_decoder_3to8_seq.sv
// Sequential N-to-2^N one-hot decoder with valid/ready intake; each word is held HOLD_CYCLES cycles.
// Optional even-parity check on code_in is enabled with `define CODE_DECODER_PARITY_EN.
module code_decoder_3to8_seq #(
    parameter int N           = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N-1:0]      code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    output logic              busy
`ifdef CODE_DECODER_PARITY_EN
    ,
    input  logic              parity_in,
    output logic              parity_err
`endif
);

    localparam int W = 2**N;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("code_decoder_3to8_seq: HOLD_CYCLES must be in 1..255");
        end
    endgenerate

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_reg, state_next;
    logic [7:0]     cnt_reg, cnt_next;
    logic [W-1:0]   y_reg, y_next;
    logic [W-1:0]   decoded;
    logic           accept;
    logic           code_ok;
    logic           load;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign decoded[gi] = (code_in == N'(gi));
        end
    endgenerate

    // Ready is gated by rst_n so nothing handshakes while reset is held.
    assign code_ready = rst_n && en && (state_reg == IDLE || cnt_reg == 8'd0);
    assign accept     = code_valid && code_ready;

`ifdef CODE_DECODER_PARITY_EN
    logic parity_err_reg;
    assign code_ok    = ~^{code_in, parity_in};
    assign parity_err = parity_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= accept && !code_ok;
        end
    end
`else
    assign code_ok = 1'b1;
`endif

    // A bad-parity code is consumed but leaves the hold machinery untouched.
    assign load = accept && code_ok;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        y_next     = y_reg;
        if (state_reg == HOLD) begin
            if (cnt_reg != 8'd0) begin
                cnt_next = cnt_reg - 8'd1;
            end else begin
                state_next = IDLE;
                y_next     = '0;
            end
        end
        if (load) begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
            y_next     = decoded;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            y_reg     <= y_next;
        end
    end

    assign y       = y_reg;
    assign busy    = (state_reg == HOLD);
    assign y_valid = busy;

endmodule

// File: tb/tb_code_decoder_3to8_seq.sv
// Directed, table-driven bench for code_decoder_3to8_seq (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
module tb_code_decoder_3to8_seq;

    typedef struct {
        logic [2:0] code;
        logic       valid;
        logic       en;
        logic [7:0] y;
        logic       yv;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       en_a = 1'b0, valid_a = 1'b0, ready_a, yv_a, busy_a;
    logic [2:0] code_a = 3'd0;
    logic [7:0] y_a;

    logic       en_b = 1'b0, valid_b = 1'b0, ready_b, yv_b, busy_b;
    logic [2:0] code_b = 3'd0;
    logic [7:0] y_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

`ifdef CODE_DECODER_PARITY_EN
    logic par_inj = 1'b0;
    logic par_a, perr_a, par_b, perr_b;
    assign par_a = (^code_a) ^ par_inj;
    assign par_b = ^code_b;
`endif

    code_decoder_3to8_seq #(.N(3), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .code_in(code_a), .code_valid(valid_a),
        .code_ready(ready_a), .y(y_a), .y_valid(yv_a), .busy(busy_a)
`ifdef CODE_DECODER_PARITY_EN
        , .parity_in(par_a), .parity_err(perr_a)
`endif
    );

    code_decoder_3to8_seq #(.N(3), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .code_in(code_b), .code_valid(valid_b),
        .code_ready(ready_b), .y(y_b), .y_valid(yv_b), .busy(busy_b)
`ifdef CODE_DECODER_PARITY_EN
        , .parity_in(par_b), .parity_err(perr_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic step_a(input vec_t v, input int idx);
        string tag;
        code_a = v.code; valid_a = v.valid; en_a = v.en;
        #1;
        tag = $sformatf("a[%0d]", idx);
        chk({tag, ".y"}, 32'(y_a), 32'(v.y));
        chk({tag, ".y_valid"}, 32'(yv_a), 32'(v.yv));
        chk({tag, ".busy"}, 32'(busy_a), 32'(v.yv));
        chk({tag, ".code_ready"}, 32'(ready_a), 32'(v.rdy));
        $display("a[%0d] code=%0d valid=%0b en=%0b -> y=%02h y_valid=%0b ready=%0b",
                 idx, v.code, v.valid, v.en, y_a, yv_a, ready_a);
        @(posedge clk); #1;
    endtask

    task automatic step_b(input vec_t v, input int idx);
        string tag;
        code_b = v.code; valid_b = v.valid; en_b = v.en;
        #1;
        tag = $sformatf("b[%0d]", idx);
        chk({tag, ".y"}, 32'(y_b), 32'(v.y));
        chk({tag, ".y_valid"}, 32'(yv_b), 32'(v.yv));
        chk({tag, ".code_ready"}, 32'(ready_b), 32'(v.rdy));
        $display("b[%0d] code=%0d valid=%0b -> y=%02h y_valid=%0b ready=%0b",
                 idx, v.code, v.valid, y_b, yv_b, ready_b);
        @(posedge clk); #1;
    endtask

    vec_t vecs[$];
    vec_t vb[5];

    function automatic vec_t mk(logic [2:0] c, logic v, logic e, logic [7:0] yy, logic yv, logic r);
        vec_t t;
        t.code = c; t.valid = v; t.en = e; t.y = yy; t.yv = yv; t.rdy = r;
        return t;
    endfunction

    initial begin
        // Single code 5 held four cycles, then idle.
        vecs.push_back(mk(3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1));
        // Stream 0..7 with valid held continuously; each code waits until ready.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(3'(i), 1'b1, 1'b1, (i == 0) ? 8'h00 : (8'h01 << (i - 1)), (i != 0), 1'b1));
            for (int j = 1; j < 4; j++)
                vecs.push_back(mk((i < 7) ? 3'(i + 1) : 3'd0, (i < 7), 1'b1, 8'h01 << i, 1'b1, 1'b0));
        end
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1));
        // Code 2, en dropped mid-hold with code 6 pending.
        vecs.push_back(mk(3'd2, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
        for (int j = 0; j < 4; j++)
            vecs.push_back(mk(3'd6, 1'b1, 1'b0, 8'h04, 1'b1, 1'b0));
        vecs.push_back(mk(3'd6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(3'd6, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
        for (int j = 0; j < 4; j++)
            vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h40, 1'b1, (j == 3)));
        vecs.push_back(mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1));

        // HOLD_CYCLES=1: codes 7,0,3 back to back.
        vb[0] = mk(3'd7, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        vb[1] = mk(3'd0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
        vb[2] = mk(3'd3, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
        vb[3] = mk(3'd0, 1'b0, 1'b1, 8'h08, 1'b1, 1'b1);
        vb[4] = mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset with en high: outputs clear and ready stays low.
        en_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset.y", 32'(y_a), 32'h0);
        chk("reset.y_valid", 32'(yv_a), 32'h0);
        chk("reset.busy", 32'(busy_a), 32'h0);
        chk("reset.code_ready", 32'(ready_a), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step_a(vecs[i], i);

        // Reset asserted during the 2nd hold cycle of code 4.
        step_a(mk(3'd4, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1), 100);
        step_a(mk(3'd0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0), 101);
        chk("midhold.y", 32'(y_a), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_midhold.y", 32'(y_a), 32'h0);
        chk("rst_midhold.y_valid", 32'(yv_a), 32'h0);
        chk("rst_midhold.busy", 32'(busy_a), 32'h0);
        chk("rst_midhold.code_ready", 32'(ready_a), 32'h0);
        $display("reset mid-hold -> y=%02h y_valid=%0b", y_a, yv_a);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step_a(mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1), 102);
        step_a(mk(3'd1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1), 103);
        step_a(mk(3'd0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0), 104);
        for (int j = 0; j < 3; j++)
            step_a(mk(3'd0, 1'b0, 1'b1, 8'h02, 1'b1, (j == 2)), 105 + j);
        step_a(mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1), 108);

        for (int i = 0; i < 5; i++) step_b(vb[i], i);

`ifdef CODE_DECODER_PARITY_EN
        par_inj = 1'b1;
        step_a(mk(3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1), 200);
        par_inj = 1'b0;
        chk("parity.err_pulse", 32'(perr_a), 32'h1);
        step_a(mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1), 201);
        chk("parity.err_clear", 32'(perr_a), 32'h0);
        step_a(mk(3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1), 202);
        chk("parity.good_no_err", 32'(perr_a), 32'h0);
        step_a(mk(3'd0, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0), 203);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
